// File: rtl/servo_cmd_sequencer.sv
// servo_cmd_sequencer: Avalon-MM command queue that plays timed pulse writes out to three servo controllers.
// Optional feature: define SEQ_IRQ_EN to build the queue-drained interrupt (irq_pend, irq_en, irq).
// Command word: [31:30] target (0 left, 1 right, 2 lift, 3 left+right), [29:20] hold ticks, [19:0] pulse time.
module servo_cmd_sequencer #(
    parameter int FIFO_DEPTH = 8,
    parameter int TICK_DIV   = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_chipselect,
    input  logic [1:0]  s_address,
    input  logic        s_write,
    input  logic        s_read,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    output logic        left_cs,
    output logic        left_write,
    output logic        right_cs,
    output logic        right_write,
    output logic        lift_cs,
    output logic        lift_write,
    output logic [31:0] servo_writedata,
    output logic        irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]    r_state, w_state_nxt;
    logic [31:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0]   r_count, w_count_nxt;
    logic [31:0]   r_cur, r_rdata, r_data, w_head, w_status;
    logic [25:0]   r_hold, w_ticks;
    logic          r_ovf, r_left, r_right, r_lift;
    logic          w_wr, w_rd, w_ctl, w_abort, w_push_req, w_full, w_pop, w_push, w_drop;
    logic          w_done, w_busy, w_irq_pend, w_irq_en;

    assign w_wr        = s_chipselect & s_write;
    assign w_rd        = s_chipselect & s_read;
    assign w_ctl       = w_wr & (s_address == 2'd2);
    assign w_abort     = w_ctl & s_writedata[0];
    assign w_push_req  = w_wr & (s_address == 2'd0) & ~w_abort;
    assign w_full      = r_count == (AW+1)'(FIFO_DEPTH);
    assign w_pop       = (r_state == S_IDLE) & (r_count != '0) & ~w_abort;
    // A pop on the same edge frees a slot, so a push into a full queue still lands.
    assign w_push      = w_push_req & (~w_full | w_pop);
    assign w_drop      = w_push_req & w_full & ~w_pop;
    assign w_head      = r_mem[r_rp];
    assign w_ticks     = 26'(r_cur[29:20]) * 26'(TICK_DIV);
    assign w_done      = ~w_abort & (((r_state == S_ISSUE) & (r_cur[29:20] == '0)) | ((r_state == S_HOLD) & (r_hold == '0)));
    assign w_count_nxt = w_abort ? '0 : r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    assign w_busy      = (r_state != S_IDLE) | (r_count != '0);
    assign w_status    = {16'b0, 8'(r_count), 3'b0, w_irq_pend, r_ovf, w_busy, r_state};

    // Next state: abort overrides everything, otherwise issue, hold and return to idle.
    always_comb
        w_state_nxt = w_abort ? S_STOP :
                      w_pop ? S_ISSUE :
                      (r_state == S_ISSUE && r_cur[29:20] != '0) ? S_HOLD :
                      (w_done || r_state == S_STOP) ? S_IDLE : r_state;

    // Sequencer state, current command and hold countdown (loaded with ticks-1 so HOLD lasts H*TICK_DIV cycles).
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_state <= S_IDLE;
            r_cur   <= '0;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pop) r_cur <= w_head;
            r_hold  <= (w_abort || r_state == S_IDLE || r_state == S_STOP) ? '0 :
                       (r_state == S_ISSUE) ? w_ticks - 26'd1 : r_hold - 26'd1;
        end

    // Queue storage needs no reset; only the pointers and count define its contents.
    always_ff @(posedge clk)
        if (w_push) r_mem[r_wp] <= s_writedata;

    // Queue pointers and occupancy; abort flushes by snapping the read pointer to the write pointer.
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            r_count <= w_count_nxt;
            r_wp    <= r_wp + AW'(w_push);
            r_rp    <= w_abort ? r_wp : r_rp + AW'(w_pop);
        end

    // Strobes are registered on the edge entering ISSUE or STOP so they cover exactly that one cycle.
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_left  <= 1'b0;
            r_right <= 1'b0;
            r_lift  <= 1'b0;
            r_data  <= '0;
        end else begin
            r_left  <= w_abort | (w_pop & ((w_head[31:30] == 2'd0) | (w_head[31:30] == 2'd3)));
            r_right <= w_abort | (w_pop & ((w_head[31:30] == 2'd1) | (w_head[31:30] == 2'd3)));
            r_lift  <= w_pop & (w_head[31:30] == 2'd2);
            r_data  <= w_abort ? '0 : w_pop ? {12'b0, w_head[19:0]} : r_data;
        end

    // Overflow flag and registered read data.
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_ovf   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ovf   <= w_drop | (r_ovf & ~(w_ctl & s_writedata[1]));
            r_rdata <= ~w_rd ? r_rdata :
                       (s_address == 2'd1) ? w_status :
                       (s_address == 2'd2) ? {29'b0, w_irq_en, 2'b0} :
                       (s_address == 2'd3) ? r_cur : '0;
        end

`ifdef SEQ_IRQ_EN
    logic r_irq_pend, r_irq_en;
    // Pending flag sets when a finished command leaves the queue empty; a simultaneous clear loses to the set.
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_irq_pend <= 1'b0;
            r_irq_en   <= 1'b0;
        end else begin
            r_irq_pend <= (w_done & (w_count_nxt == '0)) | (r_irq_pend & ~(w_ctl & s_writedata[3]));
            if (w_ctl) r_irq_en <= s_writedata[2];
        end
    assign w_irq_pend = r_irq_pend;
    assign w_irq_en   = r_irq_en;
`else
    assign w_irq_pend = 1'b0;
    assign w_irq_en   = 1'b0;
`endif

    assign irq             = w_irq_pend & w_irq_en;
    assign s_readdata      = r_rdata;
    assign servo_writedata = r_data;
    assign left_cs         = r_left;
    assign left_write      = r_left;
    assign right_cs        = r_right;
    assign right_write     = r_right;
    assign lift_cs         = r_lift;
    assign lift_write      = r_lift;
endmodule

// File: tb/tb_servo_cmd_sequencer.sv
// tb_servo_cmd_sequencer: scoreboard bench; a timing model predicts each strobe, a monitor checks it.
module tb_servo_cmd_sequencer;
    localparam int FD = 8;
    localparam int TD = 4;

    typedef struct {
        int          cyc;
        logic [5:0]  st;
        logic [31:0] d;
        bit          cmd;
    } exp_t;

    logic        clk, reset, s_chipselect, s_write, s_read;
    logic [1:0]  s_address;
    logic [31:0] s_writedata, s_readdata, servo_writedata;
    logic        left_cs, left_write, right_cs, right_write, lift_cs, lift_write, irq;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   t_free = 0;
    int   last_iss = 0;
    bit   exp_ovf = 0;
    exp_t exp_q[$];
    logic [5:0] m_act;
    exp_t m_e;

    servo_cmd_sequencer #(.FIFO_DEPTH(FD), .TICK_DIV(TD)) dut (
        .clk(clk), .reset(reset), .s_chipselect(s_chipselect), .s_address(s_address),
        .s_write(s_write), .s_read(s_read), .s_writedata(s_writedata), .s_readdata(s_readdata),
        .left_cs(left_cs), .left_write(left_write), .right_cs(right_cs), .right_write(right_write),
        .lift_cs(lift_cs), .lift_write(lift_write), .servo_writedata(servo_writedata), .irq(irq)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish want finish before timeout");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        s_chipselect = 1; s_write = 1; s_address = a; s_writedata = d;
        @(posedge clk);
        #1;
        s_chipselect = 0; s_write = 0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        s_chipselect = 1; s_read = 1; s_address = a;
        @(posedge clk);
        #1;
        s_chipselect = 0; s_read = 0;
        v = s_readdata;
    endtask

    // Model: a push lands at the next edge k unless 8 accepted commands still issue after k.
    // Issue happens the cycle after the later of k and the sequencer's next idle cycle.
    task automatic push_cmd(input logic [1:0] t, input logic [9:0] h, input logic [19:0] p);
        int k, pend;
        exp_t e;
        k = cyc + 1;
        pend = 0;
        foreach (exp_q[j]) if (exp_q[j].cmd && exp_q[j].cyc > k) pend++;
        if (pend >= FD) exp_ovf = 1;
        else begin
            last_iss = (k > t_free ? k : t_free) + 1;
            t_free = last_iss + 1 + int'(h) * TD;
            e.cyc = last_iss;
            e.st = (t == 2'd0) ? 6'b110000 : (t == 2'd1) ? 6'b001100 : (t == 2'd2) ? 6'b000011 : 6'b111100;
            e.d = {12'b0, p};
            e.cmd = 1;
            exp_q.push_back(e);
        end
        bus_wr(2'd0, {t, h, p});
    endtask

    task automatic do_abort(output int a);
        exp_t e;
        exp_t keep[$];
        a = cyc + 1;
        foreach (exp_q[j]) if (exp_q[j].cyc < a) keep.push_back(exp_q[j]);
        exp_q = keep;
        e.cyc = a; e.st = 6'b111100; e.d = '0; e.cmd = 0;
        exp_q.push_back(e);
        t_free = a + 1;
        bus_wr(2'd2, 32'h1);
    endtask

    // Monitor: every strobe must match the oldest predicted one in cycle, pattern and data.
    always @(negedge clk) begin
        if (!reset) begin
            m_act = {left_cs, left_write, right_cs, right_write, lift_cs, lift_write};
            if (m_act != 0) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_strobe: got %b at cycle %0d want none", m_act, cyc);
                end else begin
                    m_e = exp_q.pop_front();
                    chk("strobe_cycle", cyc, m_e.cyc);
                    chk("strobe_pattern", 32'(m_act), 32'(m_e.st));
                    chk("servo_data", servo_writedata, m_e.d);
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                m_e = exp_q.pop_front();
                n_cmp++; n_err++;
                $display("FAIL missed_strobe: got none want %b at cycle %0d", m_e.st, m_e.cyc);
            end
        end
    end

    initial begin
        logic [31:0] v;
        int f, a, i0;
        reset = 1; s_chipselect = 0; s_write = 0; s_read = 0; s_address = 0; s_writedata = 0;
        @(posedge clk);
        #1;
        chk("reset_strobes", {26'b0, left_cs, left_write, right_cs, right_write, lift_cs, lift_write}, 0);
        chk("reset_data", servo_writedata, 0);
        chk("reset_readdata", s_readdata, 0);
        chk("reset_irq", {31'b0, irq}, 0);
        repeat (2) @(posedge clk);
        #1 reset = 0;
        rd(2'd1, v); chk("status_reset", v, 0);
        rd(2'd2, v); chk("ctrl_reset", v, 0);
        rd(2'd3, v); chk("cur_reset", v, 0);

        // single command: left, H=3, P=5
        push_cmd(2'd0, 10'd3, 20'd5);
        f = t_free;
        wait_cyc(f - 1);
        rd(2'd1, v); chk("status_last_hold", v & ~32'h10, 32'h6);
        rd(2'd1, v); chk("status_idle_after", v & ~32'h10, 32'h0);
        rd(2'd3, v); chk("cur_word", v, 32'h0030_0005);

        // ordering: right H=0 then lift H=1, back to back
        push_cmd(2'd1, 10'd0, 20'd2);
        push_cmd(2'd2, 10'd1, 20'd4);
        wait_cyc(t_free + 2);

        // overflow while stalled in a long hold, then a push coinciding with the pop
        push_cmd(2'd0, 10'd200, 20'd1);
        wait_cyc(last_iss + 2);
        f = t_free;
        for (int i = 0; i < 9; i++) push_cmd(2'(i % 3), 10'(i % 2), 20'(100 + i));
        rd(2'd1, v); chk("ovf_status", v & ~32'h10, 32'h0000_080E);
        bus_wr(2'd2, 32'h2);
        exp_ovf = 0;
        rd(2'd1, v); chk("ovf_cleared", v & ~32'h10, 32'h0000_0806);
        wait_cyc(f);
        push_cmd(2'd2, 10'd0, 20'd777);
        wait_cyc(t_free + 2);
        chk("ovf_drained", exp_q.size(), 0);

        // abort mid-hold
        push_cmd(2'd0, 10'd2, 20'd11);
        i0 = last_iss;
        push_cmd(2'd1, 10'd1, 20'd12);
        push_cmd(2'd2, 10'd0, 20'd13);
        wait_cyc(i0 + 3);
        do_abort(a);
        wait_cyc(a + 2);
        rd(2'd1, v); chk("abort_status", v & ~32'h10, 32'h0);
        wait_cyc(a + 30);

        // interrupt
`ifdef SEQ_IRQ_EN
        bus_wr(2'd2, 32'hC);
        chk("irq_armed_low", {31'b0, irq}, 0);
        push_cmd(2'd2, 10'd0, 20'd9);
        wait_cyc(last_iss);
        chk("irq_during_issue", {31'b0, irq}, 0);
        wait_cyc(last_iss + 1);
        chk("irq_on_idle", {31'b0, irq}, 1);
        bus_wr(2'd2, 32'hC);
        chk("irq_cleared", {31'b0, irq}, 0);
        rd(2'd2, v); chk("ctrl_irq_en", v, 32'h4);
        bus_wr(2'd2, 32'h0);
`else
        bus_wr(2'd2, 32'hC);
        push_cmd(2'd2, 10'd0, 20'd9);
        wait_cyc(last_iss + 2);
        chk("irq_tied_low", {31'b0, irq}, 0);
        rd(2'd2, v); chk("ctrl_no_irq_en", v, 0);
        rd(2'd1, v); chk("status_no_pend", v, 0);
`endif

        // reset during hold
        push_cmd(2'd0, 10'd3, 20'd7);
        wait_cyc(last_iss + 2);
        rd(2'd3, v); chk("cur_before_reset", v, 32'h0030_0007);
        #1 reset = 1;
        exp_q.delete();
        t_free = 0;
        exp_ovf = 0;
        #1;
        chk("rst_async_strobes", {26'b0, left_cs, left_write, right_cs, right_write, lift_cs, lift_write}, 0);
        chk("rst_async_data", servo_writedata, 0);
        chk("rst_async_readdata", s_readdata, 0);
        chk("rst_async_irq", {31'b0, irq}, 0);
        @(posedge clk);
        #1 reset = 0;
        rd(2'd1, v); chk("rst_status", v, 0);
        rd(2'd3, v); chk("rst_cur", v, 0);
        push_cmd(2'd0, 10'd3, 20'd5);
        f = t_free;
        wait_cyc(f - 1);
        rd(2'd1, v); chk("rst_redo_hold", v & ~32'h10, 32'h6);
        rd(2'd1, v); chk("rst_redo_idle", v & ~32'h10, 32'h0);

        // randomized traffic, overflow drops included in the model
        for (int n = 0; n < 40; n++) begin
            push_cmd(2'($urandom_range(0, 3)), 10'($urandom_range(0, 2)), 20'($urandom));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        for (int i = 0; i < 5000 && exp_q.size() > 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("random_drained", exp_q.size(), 0);
        wait_cyc(t_free + 2);
        rd(2'd1, v); chk("random_final_status", v & ~32'h10, {28'b0, exp_ovf, 3'b0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
